// File: rtl/reg_file_wb.sv
// ---------------------------------------------------------------------------
// reg_file_wb
//
// Purpose:
//   MIPS32 general-purpose register file with an integrated write-back
//   scoreboard. It sits directly after the write-register select mux
//   (rt / rd / $31). Decode gets two combinational read ports (rs, rt) plus a
//   busy flag per port so it can stall on RAW hazards against in-flight
//   producers.
//
// Parameters:
//   DATA_W  register width in bits (default 32)
//   ADDR_W  register address width, 2**ADDR_W registers (default 5)
//
// Ports:
//   clk         in   1         rising-edge clock
//   rst_n       in   1         asynchronous active-low reset
//   rs_addr     in   ADDR_W    read port A address
//   rt_addr     in   ADDR_W    read port B address
//   rs_data     out  DATA_W    read port A data (combinational)
//   rt_data     out  DATA_W    read port B data (combinational)
//   rs_busy     out  1         rs_addr has a pending write (combinational)
//   rt_busy     out  1         rt_addr has a pending write (combinational)
//   issue_en    in   1         an instruction with a destination issues
//   issue_addr  in   ADDR_W    destination of the issuing instruction
//   wb_en       in   1         write-back strobe
//   wb_addr     in   ADDR_W    write-back destination
//   wb_data     in   DATA_W    write-back data
//   busy_cnt    out  ADDR_W+1  number of busy registers (registered)
//
// Configuration macro:
//   REG_BYPASS_EN  when defined, a write-back in the current cycle is
//                  forwarded to matching read ports and masks their busy
//                  flag (unless the same register is re-issued this cycle).
//                  When undefined, reads see the pre-write value until the
//                  next clock edge and busy comes only from the registered
//                  vector.
//
// Register $0 is hardwired to zero, ignores writes and is never busy.
// ---------------------------------------------------------------------------
module reg_file_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_busy,
  output logic              rt_busy,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_busy;
  logic [ADDR_W:0]   r_busyCnt;

  logic              w_wbValid;
  logic              w_issueValid;
  logic [NREG-1:0]   w_busyNext;
  logic [ADDR_W:0]   w_busyCntNext;
  logic [DATA_W-1:0] w_rsReg;
  logic [DATA_W-1:0] w_rtReg;
  logic              w_rsRegBusy;
  logic              w_rtRegBusy;

  // Writes and issues to $0 are architecturally meaningless, so they are
  // filtered once here and everything downstream can ignore address 0.
  assign w_wbValid    = wb_en    && (wb_addr    != '0);
  assign w_issueValid = issue_en && (issue_addr != '0);

  // Register storage. Entry 0 is never written, so it stays at its reset
  // value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wbValid) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Next busy vector: clear first, then set, so that when the same register
  // is written back and re-issued in one cycle the new producer keeps it busy.
  always_comb begin
    w_busyNext = r_busy;
    if (w_wbValid) begin
      w_busyNext[wb_addr] = 1'b0;
    end
    if (w_issueValid) begin
      w_busyNext[issue_addr] = 1'b1;
    end
    w_busyNext[0] = 1'b0;
  end

  // Popcount of the next busy vector so the registered count lines up with
  // the registered vector in the same cycle. Bit 0 is always zero, so the
  // maximum is NREG-1 and the ADDR_W+1 wide count can never wrap.
  always_comb begin
    w_busyCntNext = '0;
    for (int i = 0; i < NREG; i++) begin
      w_busyCntNext = w_busyCntNext + (ADDR_W+1)'(w_busyNext[i]);
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= '0;
      r_busyCnt <= '0;
    end else begin
      r_busy    <= w_busyNext;
      r_busyCnt <= w_busyCntNext;
    end
  end

  assign busy_cnt = r_busyCnt;

  // Raw array reads; $0 is forced to zero explicitly so the read path does
  // not depend on the storage entry staying clear.
  assign w_rsReg     = (rs_addr == '0) ? '0 : r_regs[rs_addr];
  assign w_rtReg     = (rt_addr == '0) ? '0 : r_regs[rt_addr];
  assign w_rsRegBusy = r_busy[rs_addr];
  assign w_rtRegBusy = r_busy[rt_addr];

`ifdef REG_BYPASS_EN
  logic w_rsFwd;
  logic w_rtFwd;
  logic w_rsReissue;
  logic w_rtReissue;

  // A same-cycle write-back satisfies the reader directly; it only stays
  // busy if a new producer claims the same register in this cycle.
  assign w_rsFwd     = w_wbValid    && (wb_addr    == rs_addr);
  assign w_rtFwd     = w_wbValid    && (wb_addr    == rt_addr);
  assign w_rsReissue = w_issueValid && (issue_addr == rs_addr);
  assign w_rtReissue = w_issueValid && (issue_addr == rt_addr);

  assign rs_data = w_rsFwd ? wb_data : w_rsReg;
  assign rt_data = w_rtFwd ? wb_data : w_rtReg;
  assign rs_busy = w_rsRegBusy && !(w_rsFwd && !w_rsReissue);
  assign rt_busy = w_rtRegBusy && !(w_rtFwd && !w_rtReissue);
`else
  assign rs_data = w_rsReg;
  assign rt_data = w_rtReg;
  assign rs_busy = w_rsRegBusy;
  assign rt_busy = w_rtRegBusy;
`endif

endmodule
